// File: rtl/utc_timekeeper.sv
// UTC time-of-day counter with a DIV-cycle prescaler, time-set loading and range checking.
// Optional alarm compare is built in when UTC_TIMEKEEPER_ALARM_EN is defined.
module utc_timekeeper #(
  parameter int unsigned DIV           = 32'd50_000_000,
  parameter logic [3:0]  TIME_SET_CODE = 4'b0101
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  STATE,
  input  logic        SET_VALID,
  input  logic [17:0] SET_DATA,
  output logic        SET_READY,
  output logic        SET_ERR,
`ifdef UTC_TIMEKEEPER_ALARM_EN
  input  logic        ALARM_SET,
  input  logic [17:0] ALARM_DATA,
  output logic        ALARM_HIT,
`endif
  output logic [17:0] CLOCK_DATA,
  output logic        SEC_TICK
);

  localparam int unsigned PW = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [PW-1:0] PMAX_C = PW'(DIV - 32'd1);

  logic [PW-1:0] presc_r;
  logic [5:0]    hour_r, min_r, sec_r;
  logic [5:0]    hour_nx_s, min_nx_s, sec_nx_s;
  logic          sec_tick_r, set_err_r;
  logic          hold_s, load_s, set_ok_s, tick_s;

  assign hold_s    = (STATE == TIME_SET_CODE);
  assign SET_READY = hold_s && !RESET;
  assign load_s    = SET_VALID && SET_READY;
  assign set_ok_s  = (SET_DATA[17:12] < 6'd24) && (SET_DATA[11:6] < 6'd60) &&
                     (SET_DATA[5:0] < 6'd60);
  // A held prescaler never ticks, so a load edge can never coincide with a tick.
  assign tick_s    = !hold_s && (presc_r == PMAX_C);

  // One-second advance of the current time with sec/min/hour carries.
  always_comb begin
    sec_nx_s  = sec_r + 6'd1;
    min_nx_s  = min_r;
    hour_nx_s = hour_r;
    if (sec_r == 6'd59) begin
      sec_nx_s = 6'd0;
      if (min_r == 6'd59) begin
        min_nx_s = 6'd0;
        if (hour_r == 6'd23) begin
          hour_nx_s = 6'd0;
        end else begin
          hour_nx_s = hour_r + 6'd1;
        end
      end else begin
        min_nx_s = min_r + 6'd1;
      end
    end else begin
      sec_nx_s = sec_r + 6'd1;
    end
  end

  // Prescaler, time registers and status pulses; reset overrides tick and load.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_r    <= '0;
      hour_r     <= 6'd0;
      min_r      <= 6'd0;
      sec_r      <= 6'd0;
      sec_tick_r <= 1'b0;
      set_err_r  <= 1'b0;
    end else begin
      sec_tick_r <= tick_s;
      set_err_r  <= load_s && !set_ok_s;
      if (load_s && set_ok_s) begin
        hour_r  <= SET_DATA[17:12];
        min_r   <= SET_DATA[11:6];
        sec_r   <= SET_DATA[5:0];
        presc_r <= '0;
      end else if (tick_s) begin
        hour_r  <= hour_nx_s;
        min_r   <= min_nx_s;
        sec_r   <= sec_nx_s;
        presc_r <= '0;
      end else if (!hold_s) begin
        presc_r <= presc_r + PW'(1'b1);
      end else begin
        presc_r <= presc_r;
      end
    end
  end

  assign CLOCK_DATA = {hour_r, min_r, sec_r};
  assign SEC_TICK   = sec_tick_r;
  assign SET_ERR    = set_err_r;

`ifdef UTC_TIMEKEEPER_ALARM_EN
  logic [17:0] alarm_r;
  logic        armed_r, alarm_hit_r;

  // Alarm time register; compared only against ticked time, never against loads.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      alarm_r     <= 18'd0;
      armed_r     <= 1'b0;
      alarm_hit_r <= 1'b0;
    end else begin
      alarm_hit_r <= tick_s && armed_r && (alarm_r == {hour_nx_s, min_nx_s, sec_nx_s});
      if (ALARM_SET) begin
        alarm_r <= ALARM_DATA;
        armed_r <= 1'b1;
      end else begin
        alarm_r <= alarm_r;
        armed_r <= armed_r;
      end
    end
  end

  assign ALARM_HIT = alarm_hit_r;
`endif

endmodule

// File: tb/tb_utc_timekeeper.sv
// Directed bench for utc_timekeeper (DIV=4) with a seconds-of-day reference model checked every cycle.
module tb_utc_timekeeper;

  localparam int DIV = 4;
  localparam logic [3:0] TSC = 4'b0101;

  logic        CLK, RESET, SET_VALID, SET_READY, SET_ERR, SEC_TICK;
  logic [3:0]  STATE;
  logic [17:0] SET_DATA, CLOCK_DATA;
`ifdef UTC_TIMEKEEPER_ALARM_EN
  logic        ALARM_SET, ALARM_HIT;
  logic [17:0] ALARM_DATA;
`endif

  utc_timekeeper #(.DIV(DIV), .TIME_SET_CODE(TSC)) dut (
    .CLK(CLK), .RESET(RESET), .STATE(STATE), .SET_VALID(SET_VALID),
    .SET_DATA(SET_DATA), .SET_READY(SET_READY), .SET_ERR(SET_ERR),
`ifdef UTC_TIMEKEEPER_ALARM_EN
    .ALARM_SET(ALARM_SET), .ALARM_DATA(ALARM_DATA), .ALARM_HIT(ALARM_HIT),
`endif
    .CLOCK_DATA(CLOCK_DATA), .SEC_TICK(SEC_TICK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  // Reference model: time as seconds of day, plus cycles elapsed in the current second.
  int secs = 0;
  int phase = 0;
  bit tick_exp = 0;
  bit err_exp = 0;
  int alarm_secs = 0;
  bit armed = 0;
  bit hit_exp = 0;
  int hit_count = 0;

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    logic [5:0] hh, mm, ss;
    hh = h[5:0]; mm = m[5:0]; ss = s[5:0];
    return {hh, mm, ss};
  endfunction

  function automatic logic [17:0] secs_to_data(input int t);
    return hms(t / 3600, (t / 60) % 60, t % 60);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      #1;
    end
  endtask

  // Model update on each rising edge, comparison of all outputs on the following falling edge.
  always begin
    @(posedge CLK);
    tick_exp = 0;
    err_exp  = 0;
    hit_exp  = 0;
    if (RESET) begin
      secs = 0; phase = 0; alarm_secs = 0; armed = 0;
    end else begin
      if (STATE == TSC) begin
        if (SET_VALID) begin
          if (int'(SET_DATA[17:12]) < 24 && int'(SET_DATA[11:6]) < 60 && int'(SET_DATA[5:0]) < 60) begin
            secs  = int'(SET_DATA[17:12]) * 3600 + int'(SET_DATA[11:6]) * 60 + int'(SET_DATA[5:0]);
            phase = 0;
          end else begin
            err_exp = 1;
          end
        end
      end else begin
        phase = phase + 1;
        if (phase == DIV) begin
          phase    = 0;
          secs     = (secs + 1) % 86400;
          tick_exp = 1;
          hit_exp  = armed && (secs == alarm_secs);
        end
      end
`ifdef UTC_TIMEKEEPER_ALARM_EN
      if (ALARM_SET) begin
        alarm_secs = int'(ALARM_DATA[17:12]) * 3600 + int'(ALARM_DATA[11:6]) * 60 + int'(ALARM_DATA[5:0]);
        armed = 1;
      end
`endif
    end
    @(negedge CLK);
    chk("clock_data", 32'(CLOCK_DATA), 32'(secs_to_data(secs)));
    chk("sec_tick", 32'(SEC_TICK), 32'(tick_exp));
    chk("set_err", 32'(SET_ERR), 32'(err_exp));
    chk("set_ready", 32'(SET_READY), 32'((STATE == TSC) && !RESET));
`ifdef UTC_TIMEKEEPER_ALARM_EN
    chk("alarm_hit", 32'(ALARM_HIT), 32'(hit_exp));
    if (ALARM_HIT) hit_count++;
`endif
  end

  initial begin
    RESET = 1'b1; STATE = 4'd0; SET_VALID = 1'b0; SET_DATA = 18'd0;
`ifdef UTC_TIMEKEEPER_ALARM_EN
    ALARM_SET = 1'b0; ALARM_DATA = 18'd0;
`endif
    cyc(2);
    chk("reset_clock", 32'(CLOCK_DATA), 32'd0);
    chk("reset_tick", 32'(SEC_TICK), 32'd0);

    // Free-running count from reset, alarm armed for 00:00:03 right after release.
    RESET = 1'b0;
`ifdef UTC_TIMEKEEPER_ALARM_EN
    ALARM_SET = 1'b1; ALARM_DATA = hms(0, 0, 3);
`endif
    cyc(1);
`ifdef UTC_TIMEKEEPER_ALARM_EN
    ALARM_SET = 1'b0;
`endif
    cyc(2);
    chk("pre_tick", 32'(SEC_TICK), 32'd0);
    cyc(1);
    chk("first_sec", 32'(CLOCK_DATA), 32'd1);
    chk("first_tick", 32'(SEC_TICK), 32'd1);
    cyc(4);
    chk("second_sec", 32'(CLOCK_DATA), 32'd2);
    cyc(4);
    chk("third_sec", 32'(CLOCK_DATA), 32'd3);
    chk("third_tick", 32'(SEC_TICK), 32'd1);

    // Load 23:59:59 and roll over to midnight one full second after leaving set mode.
    STATE = TSC; SET_VALID = 1'b1; SET_DATA = hms(23, 59, 59);
    #1 chk("ready_in_set", 32'(SET_READY), 32'd1);
    cyc(1);
    SET_VALID = 1'b0; STATE = 4'd0;
    chk("load_value", 32'(CLOCK_DATA), 32'(hms(23, 59, 59)));
    chk("load_no_tick", 32'(SEC_TICK), 32'd0);
    cyc(3);
    chk("rollover_wait", 32'(CLOCK_DATA), 32'(hms(23, 59, 59)));
    cyc(1);
    chk("rollover", 32'(CLOCK_DATA), 32'd0);
    chk("rollover_tick", 32'(SEC_TICK), 32'd1);

    // Hour carry, then out-of-range loads that must be rejected.
    STATE = TSC; SET_VALID = 1'b1; SET_DATA = hms(11, 59, 59);
    cyc(1);
    SET_DATA = hms(24, 0, 0);
    cyc(1);
    chk("err_hour", 32'(SET_ERR), 32'd1);
    SET_DATA = hms(12, 60, 0);
    cyc(1);
    chk("err_min", 32'(SET_ERR), 32'd1);
    SET_DATA = hms(0, 0, 60);
    cyc(1);
    chk("err_sec", 32'(SET_ERR), 32'd1);
    chk("err_unchanged", 32'(CLOCK_DATA), 32'(hms(11, 59, 59)));
    SET_VALID = 1'b0; STATE = 4'd0;
    cyc(1);
    chk("err_cleared", 32'(SET_ERR), 32'd0);
    cyc(3);
    chk("hour_carry", 32'(CLOCK_DATA), 32'(hms(12, 0, 0)));

    // Load request outside set mode is ignored.
    SET_VALID = 1'b1; SET_DATA = hms(5, 5, 5);
    #1 chk("ready_outside", 32'(SET_READY), 32'd0);
    cyc(4);
    SET_VALID = 1'b0;
    chk("ignored_load", 32'(CLOCK_DATA), 32'(hms(12, 0, 1)));
    chk("ignored_no_err", 32'(SET_ERR), 32'd0);

    // Reset on the edge where the prescaler would wrap.
    cyc(3);
    RESET = 1'b1;
    #1 chk("ready_in_reset", 32'(SET_READY), 32'd0);
    cyc(1);
    RESET = 1'b0;
    chk("mid_reset_clock", 32'(CLOCK_DATA), 32'd0);
    chk("mid_reset_tick", 32'(SEC_TICK), 32'd0);
    cyc(3);
    chk("post_reset_wait", 32'(SEC_TICK), 32'd0);
    cyc(1);
    chk("post_reset_tick", 32'(SEC_TICK), 32'd1);
    chk("post_reset_sec", 32'(CLOCK_DATA), 32'd1);

    // Set mode held across a partial second: count resumes from the held value.
    cyc(2);
    STATE = TSC;
    cyc(5);
    STATE = 4'd0;
    cyc(1);
    chk("held_wait", 32'(SEC_TICK), 32'd0);
    cyc(1);
    chk("held_resume", 32'(CLOCK_DATA), 32'd2);
    cyc(8);

`ifdef UTC_TIMEKEEPER_ALARM_EN
    chk("alarm_once", 32'(hit_count), 32'd1);
`endif
    cyc(1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/utc_timekeeper.md
UTC_TIMEKEEPER -- requirements
Module: utc_timekeeper

Interface
REQ-001 Parameter DIV, default 50000000, CLK cycles per second; legal range 2..2^26.
REQ-002 Parameter TIME_SET_CODE, default 4'b0101, STATE value selecting time-set mode.
REQ-003 CLK  input  1  system clock; all logic on posedge CLK.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 STATE  input  4  UI mode code from the LCD/menu controller.
REQ-006 SET_VALID  input  1  time-load request.
REQ-007 SET_DATA  input  18  load value {hour[17:12], min[11:6], sec[5:0]}, binary, UTC.
REQ-008 SET_READY  output  1  load can be accepted this cycle.
REQ-009 SET_ERR  output  1  one-cycle pulse: accepted load rejected as out of range.
REQ-010 CLOCK_DATA  output  18  current UTC time {hour, min, sec}, binary; feeds the timezone offset stage.
REQ-011 SEC_TICK  output  1  one-cycle pulse coincident with each one-second CLOCK_DATA update.

Function
REQ-012 SHALL contain a prescaler counting 0..DIV-1; width ceil(log2(DIV)).
REQ-013 SHALL hold the prescaler when STATE==TIME_SET_CODE; otherwise it increments every cycle.
REQ-014 When the prescaler is at DIV-1 and not held, it SHALL wrap to 0 and advance time by one second on the same edge.
REQ-015 SEC_TICK SHALL be registered and high for exactly the cycle in which the advanced CLOCK_DATA is first visible.
REQ-016 Advance: sec 59->0 with min carry; min 59->0 with hour carry; hour 23->0. No other wrap values.
REQ-017 CLOCK_DATA SHALL always be the registered time; hour<24, min<60, sec<60 at all times.
REQ-018 SET_READY SHALL be combinational: 1 when STATE==TIME_SET_CODE and RESET==0, else 0.
REQ-019 A load is accepted on an edge where SET_VALID and SET_READY are both 1; one cycle of SET_VALID loads exactly once.
REQ-020 An accepted load with hour<24, min<60, sec<60 SHALL make CLOCK_DATA equal SET_DATA on the next cycle and clear the prescaler to 0.
REQ-021 An accepted load with any field out of range SHALL leave time and prescaler unchanged and pulse SET_ERR for one cycle.
REQ-022 SET_VALID while SET_READY==0 SHALL be ignored, with no SET_ERR.
REQ-023 Leaving time-set mode SHALL restart counting from the held prescaler value; a full DIV cycles elapse to the first tick after a load.
REQ-024 SEC_TICK SHALL NOT assert on a load edge.

Reset
REQ-025 RESET=1 at a posedge SHALL force CLOCK_DATA=0, prescaler=0, SEC_TICK=0, SET_ERR=0 (and ALARM_HIT=0 when compiled in), overriding any tick or load that edge.
REQ-026 Reset asserted mid-second SHALL discard the partial count; the first tick occurs DIV cycles after release.

Configuration
REQ-027 Macro UTC_TIMEKEEPER_ALARM_EN: when defined, adds input ALARM_SET (1), input ALARM_DATA (18), and output ALARM_HIT (1).
REQ-028 With the macro defined, ALARM_SET=1 SHALL register ALARM_DATA as the alarm time and arm it; RESET SHALL clear the alarm time to 0 and disarm it.
REQ-029 With the macro defined, ALARM_HIT SHALL pulse one cycle, coincident with SEC_TICK, when an armed alarm matches the advanced CLOCK_DATA.
REQ-030 With the macro defined, loads via SET_DATA SHALL never fire ALARM_HIT.
REQ-031 Without the macro, the alarm ports and logic SHALL be absent and all other behaviour SHALL be identical.

Verification (DIV=4)
REQ-032 Release reset, STATE=0 -> SEC_TICK every 4 cycles; CLOCK_DATA 00:00:00 -> 00:00:01 -> 00:00:02.
REQ-033 Load 23:59:59 in time-set mode, exit mode -> after 4 cycles CLOCK_DATA=00:00:00 with SEC_TICK=1.
REQ-034 Load {24,0,0}, then {12,60,0} -> SET_ERR pulses twice; CLOCK_DATA unchanged.
REQ-035 SET_VALID with STATE!=TIME_SET_CODE -> SET_READY=0, no load, no SET_ERR; counting continues.
REQ-036 Assert RESET on the cycle the prescaler reaches 3 -> CLOCK_DATA=0, no SEC_TICK; next tick 4 cycles after release.
REQ-037 With UTC_TIMEKEEPER_ALARM_EN: alarm 00:00:03 from reset -> ALARM_HIT exactly once, together with the third SEC_TICK.
